cache_read_responder: RTL
=========================

Name: cache_read_responder

Overview:
- Consumer stage directly downstream of the cache tag lookup and master-side partner of the cache data fetcher.
- Accepts one lookup result per transaction over a valid/ready handshake.
- On a hit, drives the one-hot target way to the data fetcher, waits the fetch latency and captures the fetched data.
- Returns a response (data, hit/miss, error, request ID) to the requester over a valid/ready handshake, and keeps saturating hit/miss statistics.

Parameters:
NUM_WAYS, 4, number of cache ways; width of the one-hot way vector; legal range >= 2.
DATA_WIDTH, 32, width of fetched data and response data.
ID_WIDTH, 4, width of the request ID echoed in the response.
FETCH_LATENCY, 1, cycles from targetWay stable to dataOut valid; legal range 0..7 (0 = combinational fetcher).
STAT_WIDTH, 16, width of the hit and miss counters.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
lkpValid  input  1  lookup result valid.
lkpReady  output  1  block can accept a lookup.
lkpHit  input  1  lookup hit flag.
lkpWay  input  NUM_WAYS  one-hot hitting way; meaningful only when lkpHit=1.
lkpId  input  ID_WIDTH  request ID.
targetWay  output  NUM_WAYS  one-hot way requested from the data fetcher.
dataOut  input  DATA_WIDTH  data returned by the data fetcher.
rspValid  output  1  response valid.
rspReady  input  1  requester accepts the response.
rspData  output  DATA_WIDTH  response data; 0 on miss or error.
rspHit  output  1  response is a hit.
rspErr  output  1  lookup reported a hit with a non-one-hot way.
rspId  output  ID_WIDTH  echoed request ID.
hitCount  output  STAT_WIDTH  saturating count of successful hit responses.
missCount  output  STAT_WIDTH  saturating count of miss responses.

Behaviour:
- Reset:
  - State goes to IDLE; fetch counter = 0.
  - targetWay, rspValid, rspData, rspHit, rspErr, rspId, hitCount and missCount all = 0.
  - lkpReady = 0 while reset is high, and 1 in the first cycle after reset deasserts.
- Reset mid-transaction: the transaction is abandoned, no response is issued and counters clear.

State machine (IDLE, FETCH, RESP):
- IDLE:
  - lkpReady = 1; targetWay = 0; rspValid = 0.
  - On lkpValid && lkpReady, latch lkpId, lkpHit and lkpWay, then:
    - lkpHit=1 and lkpWay exactly one-hot -> FETCH, counter = 0.
    - lkpHit=0 -> RESP with rspHit=0, rspErr=0, rspData=0; missCount increments.
    - lkpHit=1 and lkpWay zero or multi-hot -> RESP with rspErr=1, rspHit=0, rspData=0; neither counter increments.
- FETCH:
  - lkpReady = 0; targetWay = latched way, held constant for the whole state.
  - Counter increments each cycle.
  - On the edge where counter == FETCH_LATENCY: capture dataOut into rspData, set rspHit=1, increment hitCount, go to RESP.
  - FETCH therefore lasts exactly FETCH_LATENCY+1 cycles.
- RESP:
  - rspValid = 1; targetWay = 0; lkpReady = 0.
  - rspData, rspHit, rspErr and rspId are held stable until the handshake completes.
  - On rspValid && rspReady -> IDLE.
  - rspValid never drops without rspReady.

Timing and rules:
- Hit latency: acceptance at edge N -> rspValid high in the cycle after edge N+FETCH_LATENCY+1.
- Miss and error latency: rspValid high in the cycle after the acceptance edge.
- No overlap: at most one transaction in flight. lkpReady is high only in IDLE, so a lookup presented while in RESP waits even if rspReady=1.
- Counters saturate at all-ones and do not wrap.
- dataOut is ignored outside the capture edge.
- Response outputs are registered; targetWay and lkpReady are decoded from state.
- X on lkpWay when lkpHit=0 must not propagate to any output.

Test Plan:
- FETCH_LATENCY=1, lkpHit=1, lkpWay=4'b0100, lkpId=3, fetcher returns 32'hDEADBEEF -> targetWay=4'b0100 for exactly 2 cycles; rspValid 2 cycles after acceptance with rspData=32'hDEADBEEF, rspHit=1, rspId=3; hitCount=1.
- Miss: lkpHit=0, lkpId=7 -> rspValid 1 cycle after acceptance, rspData=0, rspHit=0, rspErr=0, rspId=7; targetWay stays 0; missCount=1.
- Hit with lkpWay=4'b0110, then separately with 4'b0000 -> rspErr=1, rspHit=0, rspData=0; targetWay never asserted; both counters unchanged.
- Backpressure: hold rspReady=0 for 5 cycles while lkpValid=1 -> response outputs stable, lkpReady=0 throughout; the second lookup is accepted in the cycle after the rspReady handshake.
- Reset asserted in the middle of FETCH -> next cycle all outputs 0, no response issued; lkpReady=1 in the first cycle after reset deasserts.
- STAT_WIDTH=2: issue 5 misses -> missCount sequence 1, 2, 3, 3, 3 (saturates at 3). FETCH_LATENCY=0 hit -> targetWay asserted for 1 cycle, and data is captured combinationally in that cycle.

Source files
------------

// File: rtl/cache_read_responder.sv
// Cache read responder: takes a tag lookup result, fetches the hitting way's
// data from the data fetcher when needed, and returns a response with ID,
// hit/miss and error flags while keeping saturating hit/miss statistics.
module cache_read_responder #(
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned FETCH_LATENCY = 1,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lkpValid,
  output logic                  lkpReady,
  input  logic                  lkpHit,
  input  logic [NUM_WAYS-1:0]   lkpWay,
  input  logic [ID_WIDTH-1:0]   lkpId,
  output logic [NUM_WAYS-1:0]   targetWay,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  rspHit,
  output logic                  rspErr,
  output logic [ID_WIDTH-1:0]   rspId,
  output logic [STAT_WIDTH-1:0] hitCount,
  output logic [STAT_WIDTH-1:0] missCount
);

  // Fetch latency is at most 7, so three bits cover the counter.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_WAYS-1:0]   way_q, way_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [STAT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  // True when exactly one bit of the way vector is set.
  function automatic logic is_onehot(input logic [NUM_WAYS-1:0] w);
    return (w != '0) && ((w & (w - NUM_WAYS'(1))) == '0);
  endfunction

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      way_q      <= '0;
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      way_q      <= way_d;
      rsp_data_q <= rsp_data_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic; lkpWay is only looked at when lkpHit is set so an
  // undriven way vector on a miss never reaches the registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    way_d      = way_q;
    rsp_data_d = rsp_data_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      IDLE: begin
        if (lkpValid) begin
          rsp_id_d   = lkpId;
          rsp_data_d = '0;
          rsp_hit_d  = 1'b0;
          rsp_err_d  = 1'b0;
          way_d      = '0;
          cnt_d      = '0;
          if (!lkpHit) begin
            state_d = RESP;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_WIDTH'(1);
          end else if (is_onehot(lkpWay)) begin
            way_d   = lkpWay;
            state_d = FETCH;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      FETCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FETCH_LATENCY)) begin
          rsp_data_d = dataOut;
          rsp_hit_d  = 1'b1;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + STAT_WIDTH'(1);
          state_d = RESP;
        end
      end
      RESP: begin
        if (rspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and way select decoded from the state register.
  assign lkpReady  = (state_q == IDLE) && !reset;
  assign targetWay = (state_q == FETCH) ? way_q : '0;
  assign rspValid  = (state_q == RESP);
  assign rspData   = rsp_data_q;
  assign rspHit    = rsp_hit_q;
  assign rspErr    = rsp_err_q;
  assign rspId     = rsp_id_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;

endmodule
